lib_beat_sequencer: RTL and testbench
=====================================

Name: lib_beat_sequencer

Overview:
- Converts a frame length, given in bytes, into a stream of bus beats with a per-beat byte-keep mask and a last flag.
- Sits between a frame-descriptor source (length handshake) and a byte-lane datapath (beat handshake).
- Derives the final-beat keep mask as a bin-to-valid thermometer code: low (n+1) bits set for bin value n.
- Owns the sequencing state machine and the beat counter for the datapath it drives.

Parameters:
BYTES_PER_BEAT, 8, byte lanes per beat; power of two, >= 2, else elaboration error.
LEN_WIDTH, 16, width of the frame length in bytes.
KW, $clog2(BYTES_PER_BEAT), lane-index width; derived, not overridden.
CW, LEN_WIDTH-KW+1, beat counter width; derived.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort of the current frame.
len_vld  input  1  frame length valid.
len  input  LEN_WIDTH  frame length in bytes.
len_rdy  output  1  length accepted when len_vld & len_rdy.
beat_vld  output  1  beat valid.
beat_rdy  input  1  downstream accepts beat when beat_vld & beat_rdy.
beat_keep  output  BYTES_PER_BEAT  byte-valid mask of current beat.
beat_last  output  1  current beat is last of frame.
beat_idx  output  CW  zero-based index of current beat within frame.
err_zero_len  output  1  one-cycle pulse: len==0 was accepted and dropped.

Behaviour:
- Clocking and reset: single clock domain. rst_n is asynchronous and active-low; assertion forces reset values immediately, mid-frame included.
- Reset values: state=IDLE, beat_vld=0, beat_last=0, beat_keep=0, beat_idx=0, err_zero_len=0. len_rdy=1 while rst_n=1 and state=IDLE.
- States:
  - IDLE: beat_vld=0, len_rdy=1.
  - RUN: beat_vld=1.
- Length capture, on len_vld & len_rdy & !flush:
  - len != 0: latch total=ceil(len/BYTES_PER_BEAT) (CW bits), last_bin=(len-1)[KW-1:0], beat_idx=0. Go to RUN; beat_vld=1 on the next cycle (1-cycle latency).
  - len == 0: no beats. err_zero_len=1 for exactly the next cycle. State unchanged (IDLE, or IDLE after a last-beat transfer).
- Beat outputs in RUN:
  - beat_last = (beat_idx == total-1).
  - beat_keep = all ones when !beat_last; thermometer(last_bin) when beat_last.
  - Outputs are registered and hold stable while beat_vld & !beat_rdy.
- Beat transfer, on beat_vld & beat_rdy:
  - Not last: beat_idx increments by 1 on the next cycle.
  - Last: the frame ends.
- Back-to-back frames: len_rdy = (state==IDLE) | (beat_vld & beat_last & beat_rdy & !flush). This is a combinational path from beat_rdy.
  - Length accepted in the same cycle as the last-beat transfer: the next frame's beat 0 is valid on the next cycle, with no bubble.
  - Otherwise the block returns to IDLE.
- flush (highest priority after reset):
  - Next cycle: state=IDLE, beat_vld=0, beat_idx=0.
  - No length is accepted in a flush cycle; len_rdy=0 while flush=1.
  - A beat transfer coinciding with flush is still counted as delivered downstream; the block does not retract it.
- Arithmetic: total = (len + BYTES_PER_BEAT-1) >> KW, computed in CW bits, with no overflow at len = 2^LEN_WIDTH-1.
- Boundary cases:
  - len an exact multiple of BYTES_PER_BEAT gives a full final keep.
  - len <= BYTES_PER_BEAT gives a single beat with beat_last=1 at beat_idx=0.
- beat_vld never deasserts in RUN without a last-beat transfer, flush, or reset.
- Implementation: behavioural or structural, 120-400 lines. The thermometer decode is a parameterised function or generate table covering all KW-bit values.

Test Plan:
- BYTES_PER_BEAT=8, len=13, beat_rdy=1 -> beats: idx0 keep=FF last=0, idx1 keep=1F last=1. len_rdy=0 during RUN, back to 1 after.
- len=8, then len=1 -> single beat keep=FF last=1, then single beat keep=01 last=1. len=16 -> 2 beats, both keep=FF.
- len=20 with beat_rdy toggling 1,0,0,1,... -> outputs hold during stalls. Sequence FF, FF, 0F. beat_idx 0,1,2 with no skips.
- Frame A len=9, frame B len=3 presented with len_vld held -> B accepted in A's last-beat cycle. Beat stream FF, 01(last), 07(last) with no idle cycle.
- len=0 -> err_zero_len pulses one cycle, no beat_vld, len_rdy stays 1. len=65535 -> 8192 beats, final keep=7F, beat_idx ends at 8191.
- Frame len=40: flush at beat_idx=2 -> beat_vld=0 next cycle, new len=5 accepted afterwards gives keep=1F idx0. rst_n low mid-frame -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/lib_beat_sequencer.sv
// Frame-length to bus-beat sequencer: turns a byte count into a stream of beats
// carrying a byte-keep mask, a last flag and a beat index.
module lib_beat_sequencer #(
  parameter int BYTES_PER_BEAT = 8,
  parameter int LEN_WIDTH      = 16,
  localparam int KW            = $clog2(BYTES_PER_BEAT),
  localparam int CW            = LEN_WIDTH - KW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      len_vld,
  input  logic [LEN_WIDTH-1:0]      len,
  output logic                      len_rdy,
  output logic                      beat_vld,
  input  logic                      beat_rdy,
  output logic [BYTES_PER_BEAT-1:0] beat_keep,
  output logic                      beat_last,
  output logic [CW-1:0]             beat_idx,
  output logic                      err_zero_len
);

  generate
    if (BYTES_PER_BEAT < 2 || (BYTES_PER_BEAT & (BYTES_PER_BEAT - 1)) != 0) begin : g_bad_bpb
      $error("lib_beat_sequencer: BYTES_PER_BEAT must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_reg, state_next;
  logic [CW-1:0]             total_reg, total_next;
  logic [CW-1:0]             beat_idx_reg, beat_idx_next;
  logic [KW-1:0]             last_bin_reg, last_bin_next;
  logic [BYTES_PER_BEAT-1:0] keep_reg, keep_next;
  logic                      last_reg, last_next;
  logic                      err_reg, err_next;

  // Thermometer table: entry n has the low n+1 lanes set.
  logic [BYTES_PER_BEAT-1:0] therm_table [BYTES_PER_BEAT];
  generate
    for (genvar gi = 0; gi < BYTES_PER_BEAT; gi++) begin : g_therm
      assign therm_table[gi] = {BYTES_PER_BEAT{1'b1}} >> (BYTES_PER_BEAT - 1 - gi);
    end
  endgenerate

  // One extra bit keeps the round-up sum from wrapping at the maximum length.
  logic [LEN_WIDTH:0] len_round;
  logic [CW-1:0]      len_total;
  logic [KW-1:0]      len_bin;
  logic               len_first_last;
  logic               len_zero;
  logic [CW-1:0]      idx_inc;
  logic               inc_last;
  logic               beat_xfer;
  logic               last_xfer;
  logic               len_acc;

  assign len_round      = {1'b0, len} + (LEN_WIDTH + 1)'(BYTES_PER_BEAT - 1);
  assign len_total      = CW'(len_round >> KW);
  assign len_bin        = len[KW-1:0] - KW'(1);
  assign len_first_last = (len_total == CW'(1));
  assign len_zero       = (len == '0);
  assign idx_inc        = beat_idx_reg + CW'(1);
  assign inc_last       = (idx_inc == total_reg - CW'(1));

  assign beat_xfer = beat_vld & beat_rdy;
  assign last_xfer = beat_xfer & last_reg;
  assign len_acc   = len_vld & len_rdy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else if (len_acc && !len_zero) begin
      state_next = RUN;
    end else if (last_xfer) begin
      state_next = IDLE;
    end
  end

  // Output logic; len_rdy deliberately sees beat_rdy so frames chain without a bubble.
  always_comb begin
    beat_vld = (state_reg == RUN);
    len_rdy  = rst_n & ~flush & ((state_reg == IDLE) | last_xfer);
  end

  always_comb begin
    total_next    = total_reg;
    last_bin_next = last_bin_reg;
    beat_idx_next = beat_idx_reg;
    keep_next     = keep_reg;
    last_next     = last_reg;
    err_next      = 1'b0;
    if (flush) begin
      beat_idx_next = '0;
      keep_next     = '0;
      last_next     = 1'b0;
    end else begin
      if (len_acc && len_zero) begin
        err_next = 1'b1;
      end
      if (len_acc && !len_zero) begin
        total_next    = len_total;
        last_bin_next = len_bin;
        beat_idx_next = '0;
        last_next     = len_first_last;
        keep_next     = len_first_last ? therm_table[len_bin] : {BYTES_PER_BEAT{1'b1}};
      end else if (last_xfer) begin
        beat_idx_next = '0;
        keep_next     = '0;
        last_next     = 1'b0;
      end else if (beat_xfer) begin
        beat_idx_next = idx_inc;
        last_next     = inc_last;
        keep_next     = inc_last ? therm_table[last_bin_reg] : {BYTES_PER_BEAT{1'b1}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_reg    <= '0;
      last_bin_reg <= '0;
      beat_idx_reg <= '0;
      keep_reg     <= '0;
      last_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      total_reg    <= total_next;
      last_bin_reg <= last_bin_next;
      beat_idx_reg <= beat_idx_next;
      keep_reg     <= keep_next;
      last_reg     <= last_next;
      err_reg      <= err_next;
    end
  end

  assign beat_keep    = keep_reg;
  assign beat_last    = last_reg;
  assign beat_idx     = beat_idx_reg;
  assign err_zero_len = err_reg;

endmodule

// File: tb/tb_lib_beat_sequencer.sv
// Self-checking bench for lib_beat_sequencer: table-driven frames plus
// hand-written back-to-back, zero-length, flush and reset sequences.
module tb_lib_beat_sequencer;

  localparam int BPB = 8;
  localparam int LW  = 16;
  localparam int CW  = 14;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           len_vld;
  logic [LW-1:0]  len;
  logic           len_rdy;
  logic           beat_vld;
  logic           beat_rdy;
  logic [BPB-1:0] beat_keep;
  logic           beat_last;
  logic [CW-1:0]  beat_idx;
  logic           err_zero_len;

  lib_beat_sequencer #(.BYTES_PER_BEAT(BPB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .len_vld(len_vld), .len(len),
    .len_rdy(len_rdy), .beat_vld(beat_vld), .beat_rdy(beat_rdy),
    .beat_keep(beat_keep), .beat_last(beat_last), .beat_idx(beat_idx),
    .err_zero_len(err_zero_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;
  int cyc = 0;
  logic [22:0] exp_q [$];

  typedef struct {
    logic [LW-1:0]  len;
    int             n_beats;
    logic [BPB-1:0] last_keep;
    int             rdy_mode;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int n, input logic [BPB-1:0] kf);
    logic [CW-1:0]  ii;
    logic [BPB-1:0] kk;
    logic           ll;
    for (int i = 0; i < n; i++) begin
      ii = i[CW-1:0];
      ll = (i == n - 1);
      kk = ll ? kf : 8'hFF;
      exp_q.push_back({ii, kk, ll});
    end
  endtask

  task automatic send_len(input logic [LW-1:0] l, output bit ok, output bit vld_at_acc);
    @(posedge clk); #1;
    len = l;
    len_vld = 1'b1;
    ok = 1'b0;
    vld_at_acc = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (len_rdy) begin
        ok = 1'b1;
        vld_at_acc = beat_vld;
        break;
      end
    end
    @(posedge clk); #1;
    len_vld = 1'b0;
    chk("len_accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !beat_vld) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", {63'd0, done}, 64'd1);
  endtask

  // Ready driver: always ready, or the 1,0,0 repeating stall pattern.
  initial begin
    beat_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      beat_rdy = (rdy_mode == 1) ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Scoreboard monitor: every accepted beat must match the head of the queue.
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && beat_vld && beat_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got idx=%0d keep=%h last=%b, required no beat",
                   beat_idx, beat_keep, beat_last);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {41'd0, beat_idx, beat_keep, beat_last}, {41'd0, e});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    bit ok, vaa;

    vecs[0] = '{16'd13,    2,    8'h1F, 0};
    vecs[1] = '{16'd8,     1,    8'hFF, 0};
    vecs[2] = '{16'd1,     1,    8'h01, 0};
    vecs[3] = '{16'd16,    2,    8'hFF, 0};
    vecs[4] = '{16'd20,    3,    8'h0F, 1};
    vecs[5] = '{16'd7,     1,    8'h7F, 0};
    vecs[6] = '{16'd65535, 8192, 8'h7F, 0};

    rst_n = 1'b0;
    flush = 1'b0;
    len_vld = 1'b0;
    len = '0;
    #2;
    chk("rst_vld",  {63'd0, beat_vld}, 64'd0);
    chk("rst_keep", {56'd0, beat_keep}, 64'd0);
    chk("rst_last", {63'd0, beat_last}, 64'd0);
    chk("rst_idx",  {50'd0, beat_idx}, 64'd0);
    chk("rst_err",  {63'd0, err_zero_len}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_len_rdy", {63'd0, len_rdy}, 64'd1);

    for (int v = 0; v < 7; v++) begin
      rdy_mode = vecs[v].rdy_mode;
      push_frame(vecs[v].n_beats, vecs[v].last_keep);
      send_len(vecs[v].len, ok, vaa);
      @(negedge clk);
      chk("first_vld", {63'd0, beat_vld}, 64'd1);
      chk("first_idx", {50'd0, beat_idx}, 64'd0);
      if (vecs[v].n_beats > 1) chk("len_rdy_in_run", {63'd0, len_rdy}, 64'd0);
      wait_idle(vecs[v].n_beats * 4 + 20);
      chk("len_rdy_after", {63'd0, len_rdy}, 64'd1);
      $display("frame len=%0d beats=%0d rdy_mode=%0d done", vecs[v].len, vecs[v].n_beats, vecs[v].rdy_mode);
    end
    rdy_mode = 0;

    // Back-to-back: B presented during A and taken in A's last-beat cycle.
    push_frame(2, 8'h01);
    push_frame(1, 8'h07);
    send_len(16'd9, ok, vaa);
    send_len(16'd3, ok, vaa);
    chk("b2b_acc_in_last", {63'd0, vaa}, 64'd1);
    @(negedge clk);
    chk("b2b_no_bubble", {54'd0, beat_vld, beat_keep, beat_last}, {54'd0, 1'b1, 8'h07, 1'b1});
    wait_idle(40);
    $display("frame b2b len=9,3 done");

    // Zero length: one-cycle error pulse, no beats.
    send_len(16'd0, ok, vaa);
    @(negedge clk);
    chk("zero_err", {63'd0, err_zero_len}, 64'd1);
    chk("zero_vld", {63'd0, beat_vld}, 64'd0);
    chk("zero_rdy", {63'd0, len_rdy}, 64'd1);
    @(negedge clk);
    chk("zero_err_end", {63'd0, err_zero_len}, 64'd0);
    $display("frame len=0 done");

    // Flush in IDLE blocks length acceptance.
    @(posedge clk); #1;
    flush = 1'b1;
    len_vld = 1'b1;
    len = 16'd4;
    #1;
    chk("flush_len_rdy", {63'd0, len_rdy}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    len_vld = 1'b0;
    @(negedge clk);
    chk("flush_no_frame", {63'd0, beat_vld}, 64'd0);
    $display("flush idle done");

    // Flush mid-frame at beat 2, then a fresh frame.
    push_frame(5, 8'hFF);
    send_len(16'd40, ok, vaa);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (beat_vld && beat_idx == 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("flush_reach_idx2", {63'd0, ok}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_vld", {63'd0, beat_vld}, 64'd0);
    chk("flush_idx", {50'd0, beat_idx}, 64'd0);
    push_frame(1, 8'h1F);
    send_len(16'd5, ok, vaa);
    wait_idle(20);
    $display("frame len=40 flushed, len=5 done");

    // Asynchronous reset mid-frame.
    push_frame(5, 8'hFF);
    send_len(16'd40, ok, vaa);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld",  {63'd0, beat_vld}, 64'd0);
    chk("arst_keep", {56'd0, beat_keep}, 64'd0);
    chk("arst_idx",  {50'd0, beat_idx}, 64'd0);
    chk("arst_last", {63'd0, beat_last}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(1, 8'h01);
    send_len(16'd1, ok, vaa);
    wait_idle(20);
    $display("async reset mid-frame done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
